sdram_port_arbiter: RTL and testbench



---
 rtl/sdram_port_arbiter_pkg.sv | 19 +
 rtl/port_owner_fifo.sv | 64 ++++++
 rtl/sdram_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and helpers for the SDRAM port arbiter.
// State encoding and a constant-time log2 used for sizing.
package sdram_port_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/port_owner_fifo.sv
// In-order FIFO remembering which port issued each outstanding read burst.
// Depth is 2**AW; push is ignored when full, pop when empty.
module port_owner_fifo #(
    parameter int W  = 1,
    parameter int AW = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == (AW + 1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign dout    = mem_q[rptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW + 1)'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter between wb_port clients and one SDRAM controller.
// Commands go to the granted port; read beats follow an owner FIFO.
module sdram_port_arbiter
    import sdram_port_arbiter_pkg::*;
#(
    parameter int NR_PORTS   = 2,
    parameter int DQ_WIDTH   = 16,
    parameter int BURST_LEN  = 8,
    parameter int RD_FIFO_AW = 2,
    parameter int MAX_CMDS   = 4
) (
    input  logic                         sdram_clk,
    input  logic                         sdram_rst,
    input  logic [NR_PORTS-1:0]          p_acc_i,
    input  logic [NR_PORTS-1:0]          p_we_i,
    input  logic [32*NR_PORTS-1:0]       p_adr_i,
    input  logic [DQ_WIDTH*NR_PORTS-1:0] p_dat_i,
    input  logic [2*NR_PORTS-1:0]        p_sel_i,
    input  logic [NR_PORTS-1:0]          p_dv_i,
    output logic [NR_PORTS-1:0]          p_ack_o,
    output logic [NR_PORTS-1:0]          p_vld_o,
    output logic [DQ_WIDTH-1:0]          p_dat_o,
    output logic [31:0]                  p_adr_o,
    output logic                         acc_o,
    output logic                         we_o,
    output logic [31:0]                  adr_o,
    output logic [DQ_WIDTH-1:0]          dat_o,
    output logic [1:0]                   sel_o,
    output logic                         dv_o,
    input  logic                         ack_i,
    input  logic                         vld_i,
    input  logic [31:0]                  adr_i,
    input  logic [DQ_WIDTH-1:0]          dat_i,
    output logic                         err_o
);

    localparam int PW = (clog2(NR_PORTS) > 0) ? clog2(NR_PORTS) : 1;
    localparam int BW = (clog2(BURST_LEN) > 0) ? clog2(BURST_LEN) : 1;
    localparam int CW = clog2(MAX_CMDS + 1);

    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [CW-1:0] CMD_LIMIT = CW'(MAX_CMDS);
    localparam logic [PW-1:0] LAST_RST  = PW'(NR_PORTS - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] gnt_q, gnt_d;
    logic [PW-1:0] last_q, last_d;
    logic [CW-1:0] ncmd_q, ncmd_d;
    logic [BW-1:0] beat_q, beat_d;
    logic          err_q, err_d;

    logic [NR_PORTS-1:0][31:0]         adr_v;
    logic [NR_PORTS-1:0][DQ_WIDTH-1:0] dat_v;
    logic [NR_PORTS-1:0][1:0]          sel_v;

    logic          granted;
    logic          hs;
    logic          beat_ok;
    logic          f_push, f_pop, f_full, f_empty;
    logic [PW-1:0] f_head;

    assign adr_v = p_adr_i;
    assign dat_v = p_dat_i;
    assign sel_v = p_sel_i;

    // First requester strictly after the previous owner, wrapping around.
    function automatic logic [PW-1:0] rr_pick(
        input logic [NR_PORTS-1:0] req,
        input logic [PW-1:0]       last
    );
        logic [PW-1:0] pick;
        logic [PW-1:0] idx;
        pick = last;
        for (int i = NR_PORTS; i >= 1; i--) begin
            idx = PW'((int'(last) + i) % NR_PORTS);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    always_comb begin
        granted = (state_q == ST_GRANT);
        acc_o   = 1'b0;
        we_o    = 1'b0;
        adr_o   = '0;
        dat_o   = '0;
        sel_o   = '0;
        dv_o    = 1'b0;
        p_ack_o = '0;
        if (granted) begin
            // Reads stall while every owner slot is taken; writes need none.
            acc_o   = p_acc_i[gnt_q] & ~(~p_we_i[gnt_q] & f_full);
            we_o    = p_we_i[gnt_q];
            adr_o   = adr_v[gnt_q];
            dat_o   = dat_v[gnt_q];
            sel_o   = sel_v[gnt_q];
            dv_o    = p_dv_i[gnt_q];
            p_ack_o = NR_PORTS'(ack_i) << gnt_q;
        end
        hs = acc_o & ack_i;
    end

    assign beat_ok = vld_i & ~f_empty;
    assign f_push  = hs & ~we_o;
    assign f_pop   = beat_ok & (beat_q == LAST_BEAT);
    assign p_vld_o = beat_ok ? (NR_PORTS'(1) << f_head) : '0;
    assign p_dat_o = dat_i;
    assign p_adr_o = adr_i;
    assign err_o   = err_q;

    port_owner_fifo #(
        .W  (PW),
        .AW (RD_FIFO_AW)
    ) u_owner_fifo (
        .clk   (sdram_clk),
        .rst   (sdram_rst),
        .push  (f_push),
        .pop   (f_pop),
        .din   (gnt_q),
        .dout  (f_head),
        .full  (f_full),
        .empty (f_empty)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        ncmd_d  = ncmd_q;
        beat_d  = beat_q;
        err_d   = err_q | (vld_i & f_empty);
        unique case (state_q)
            ST_IDLE: begin
                if (|p_acc_i) begin
                    gnt_d   = rr_pick(p_acc_i, last_q);
                    ncmd_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (hs && ncmd_q != CMD_LIMIT) begin
                    ncmd_d = ncmd_q + CW'(1);
                end
                if (!p_acc_i[gnt_q] || (ncmd_q == CMD_LIMIT && !hs)) begin
                    last_d  = gnt_q;
                    state_d = ST_IDLE;
                end
            end
        endcase
        if (beat_ok) begin
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + BW'(1);
        end
    end

    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            last_q  <= LAST_RST;
            ncmd_q  <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            ncmd_q  <= ncmd_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: vector table, directed
// multi-cycle sequences and a random run against a behavioural model.
module tb_sdram_port_arbiter;

    localparam int N     = 2;
    localparam int DQ    = 16;
    localparam int BL    = 8;
    localparam int AW    = 2;
    localparam int MAXC  = 4;
    localparam int DEPTH = 1 << AW;

    logic          sdram_clk = 1'b0;
    logic          sdram_rst;
    logic [N-1:0]  p_acc, p_we, p_dv;
    logic [63:0]   p_adr;
    logic [31:0]   p_dat;
    logic [3:0]    p_sel;
    logic [N-1:0]  p_ack_o, p_vld_o;
    logic [DQ-1:0] p_dat_o;
    logic [31:0]   p_adr_o;
    logic          acc_o, we_o, dv_o, err_o;
    logic [31:0]   adr_o;
    logic [DQ-1:0] dat_o;
    logic [1:0]    sel_o;
    logic          ack_i, vld_i;
    logic [31:0]   adr_i;
    logic [DQ-1:0] dat_i;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 sdram_clk = ~sdram_clk;

    sdram_port_arbiter #(
        .NR_PORTS   (N),
        .DQ_WIDTH   (DQ),
        .BURST_LEN  (BL),
        .RD_FIFO_AW (AW),
        .MAX_CMDS   (MAXC)
    ) dut (
        .sdram_clk (sdram_clk),
        .sdram_rst (sdram_rst),
        .p_acc_i   (p_acc),
        .p_we_i    (p_we),
        .p_adr_i   (p_adr),
        .p_dat_i   (p_dat),
        .p_sel_i   (p_sel),
        .p_dv_i    (p_dv),
        .p_ack_o   (p_ack_o),
        .p_vld_o   (p_vld_o),
        .p_dat_o   (p_dat_o),
        .p_adr_o   (p_adr_o),
        .acc_o     (acc_o),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .dat_o     (dat_o),
        .sel_o     (sel_o),
        .dv_o      (dv_o),
        .ack_i     (ack_i),
        .vld_i     (vld_i),
        .adr_i     (adr_i),
        .dat_i     (dat_i),
        .err_o     (err_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [51:0] dut_bus();
        return {we_o, adr_o, dat_o, sel_o, dv_o};
    endfunction

    task automatic clear_inputs();
        p_acc = '0; p_we = '0; p_dv = '0; p_sel = '0;
        p_adr = {32'h2000_0000, 32'h1000_0000};
        p_dat = {16'hbbbb, 16'haaaa};
        ack_i = 1'b0; vld_i = 1'b0; adr_i = '0; dat_i = '0;
    endtask

    task automatic do_reset();
        sdram_rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge sdram_clk);
        @(negedge sdram_clk);
        check("rst_acc", 64'(acc_o), 64'(0));
        check("rst_ack", 64'(p_ack_o), 64'(0));
        check("rst_vld", 64'(p_vld_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        check("rst_bus", 64'(dut_bus()), 64'(0));
        @(posedge sdram_clk); #1;
        sdram_rst = 1'b0;
    endtask

    // Controller stand-in: ack every other cycle while acc_o is high.
    task automatic issue(input int port, input logic we, input int n, input bit keep);
        int got;
        bit prev;
        got = 0;
        prev = 0;
        p_acc = p_acc | (2'b01 << port);
        if (we) p_we = p_we | (2'b01 << port);
        else    p_we = p_we & ~(2'b01 << port);
        for (int c = 0; c < 60 && got < n; c++) begin
            @(negedge sdram_clk);
            ack_i = acc_o && !prev;
            if (ack_i) got++;
            @(posedge sdram_clk);
            prev = ack_i;
            #1;
            ack_i = 1'b0;
        end
        check("issue_acks", 64'(got), 64'(n));
        if (!keep) p_acc = p_acc & ~(2'b01 << port);
    endtask

    typedef struct {
        logic [1:0] acc;
        logic       ack;
        logic       vld;
        logic       e_acc;
        logic [1:0] e_ack;
        logic [1:0] e_vld;
        logic       e_err;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic [1:0] a, logic k, logic v,
                                logic ea, logic [1:0] ek, logic [1:0] ev, logic ee);
        vec_t r;
        r.acc = a; r.ack = k; r.vld = v;
        r.e_acc = ea; r.e_ack = ek; r.e_vld = ev; r.e_err = ee;
        return r;
    endfunction

    // Behavioural model state
    int         m_gnt, m_ncmd, m_last, m_beat;
    bit         m_err;
    int         q[$];
    logic       e_acc;
    logic [1:0] e_ack, e_vld;
    logic [51:0] e_bus;

    task automatic model_reset();
        m_gnt = -1; m_ncmd = 0; m_last = N - 1; m_beat = 0; m_err = 0;
        q.delete();
    endtask

    task automatic model_comb();
        int g;
        g = m_gnt;
        e_acc = 0; e_ack = '0; e_bus = '0; e_vld = '0;
        if (g >= 0) begin
            e_acc = ((p_acc >> g) & 1) != 0;
            if (((p_we >> g) & 1) == 0 && q.size() == DEPTH) e_acc = 0;
            e_bus = {1'(p_we >> g), 32'(p_adr >> (32 * g)), 16'(p_dat >> (16 * g)),
                     2'(p_sel >> (2 * g)), 1'(p_dv >> g)};
            if (ack_i) e_ack = 2'b01 << g;
        end
        if (vld_i && q.size() > 0) e_vld = 2'b01 << q[0];
    endtask

    task automatic model_step();
        bit hs;
        int cur;
        hs = e_acc && ack_i;
        if (vld_i) begin
            if (q.size() > 0) begin
                m_beat++;
                if (m_beat == BL) begin
                    m_beat = 0;
                    void'(q.pop_front());
                end
            end else begin
                m_err = 1;
            end
        end
        if (m_gnt >= 0) begin
            cur = m_ncmd;
            if (hs) begin
                if (m_ncmd < MAXC) m_ncmd++;
                if (((p_we >> m_gnt) & 1) == 0) q.push_back(m_gnt);
            end
            if (((p_acc >> m_gnt) & 1) == 0 || (cur == MAXC && !hs)) begin
                m_last = m_gnt;
                m_gnt = -1;
            end
        end else if (p_acc != 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_gnt < 0 && ((p_acc >> c) & 1) != 0) m_gnt = c;
            end
            m_ncmd = 0;
        end
    endtask

    initial begin
        int own[16];
        int acks, gap, cyc;
        bit prev;

        // ---- table: single port-0 read, 8 beats, then a stray beat
        tbl[0]  = mk(2'b01, 0, 0, 0, 2'b00, 2'b00, 0);
        tbl[1]  = mk(2'b01, 0, 0, 1, 2'b00, 2'b00, 0);
        tbl[2]  = mk(2'b01, 0, 0, 1, 2'b00, 2'b00, 0);
        tbl[3]  = mk(2'b01, 1, 0, 1, 2'b01, 2'b00, 0);
        tbl[4]  = mk(2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        for (int i = 5; i <= 12; i++) tbl[i] = mk(2'b00, 0, 1, 0, 2'b00, 2'b01, 0);
        tbl[13] = mk(2'b00, 0, 0, 0, 2'b00, 2'b00, 0);
        tbl[14] = mk(2'b00, 0, 1, 0, 2'b00, 2'b00, 0);
        tbl[15] = mk(2'b00, 0, 0, 0, 2'b00, 2'b00, 1);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            p_acc = tbl[i].acc; ack_i = tbl[i].ack; vld_i = tbl[i].vld;
            @(negedge sdram_clk);
            check($sformatf("tbl%0d_acc", i), 64'(acc_o), 64'(tbl[i].e_acc));
            check($sformatf("tbl%0d_ack", i), 64'(p_ack_o), 64'(tbl[i].e_ack));
            check($sformatf("tbl%0d_vld", i), 64'(p_vld_o), 64'(tbl[i].e_vld));
            check($sformatf("tbl%0d_err", i), 64'(err_o), 64'(tbl[i].e_err));
            @(posedge sdram_clk); #1;
        end

        // ---- rotation: both ports write, 4 commands each, one idle cycle
        do_reset();
        p_acc = 2'b11; p_we = 2'b11;
        acks = 0; gap = 0; prev = 0;
        for (int c = 0; c < 80 && acks < 16; c++) begin
            @(negedge sdram_clk);
            ack_i = acc_o && !prev;
            #1;
            if (ack_i) begin
                own[acks] = p_ack_o[1] ? 1 : 0;
                acks++;
            end else if (acks == 4 && !acc_o) begin
                gap++;
            end
            @(posedge sdram_clk);
            prev = ack_i;
            #1;
            ack_i = 1'b0;
        end
        check("rr_acks", 64'(acks), 64'(16));
        for (int k = 0; k < 16; k++) check($sformatf("rr_order%0d", k), 64'(own[k]), 64'((k / 4) % 2));
        check("rr_gap", 64'(gap), 64'(1));
        clear_inputs();

        // ---- owner steering: two reads port 0, one read port 1
        do_reset();
        issue(0, 1'b0, 2, 0);
        issue(1, 1'b0, 1, 0);
        for (int b = 0; b < 24; b++) begin
            vld_i = 1'b1; dat_i = DQ'(b + 16'h100);
            @(negedge sdram_clk);
            check($sformatf("steer_b%0d", b), 64'(p_vld_o), 64'(b < 16 ? 2'b01 : 2'b10));
            if (b == 5) check("steer_dat", 64'(p_dat_o), 64'(16'h105));
            @(posedge sdram_clk); #1;
        end
        vld_i = 1'b0;

        // ---- owner FIFO full: read held, write passes, release on pop
        do_reset();
        issue(0, 1'b0, 4, 0);
        p_acc = 2'b01; p_we = 2'b00;
        for (int c = 0; c < 4; c++) begin
            @(negedge sdram_clk);
            check($sformatf("full_hold%0d", c), 64'(acc_o), 64'(0));
            @(posedge sdram_clk); #1;
        end
        p_we = 2'b01;
        @(negedge sdram_clk);
        check("full_wr_acc", 64'(acc_o), 64'(1));
        ack_i = 1'b1;
        #1;
        check("full_wr_ack", 64'(p_ack_o), 64'(2'b01));
        @(posedge sdram_clk); #1;
        ack_i = 1'b0; p_we = 2'b00;
        for (int b = 0; b < BL; b++) begin
            vld_i = 1'b1;
            @(negedge sdram_clk);
            check($sformatf("full_beat%0d", b), 64'({acc_o, p_vld_o}), 64'({1'b0, 2'b01}));
            @(posedge sdram_clk); #1;
        end
        vld_i = 1'b0;
        @(negedge sdram_clk);
        check("full_release", 64'(acc_o), 64'(1));
        @(posedge sdram_clk); #1;

        // ---- reset during grant with reads outstanding
        do_reset();
        issue(1, 1'b0, 2, 1);
        @(negedge sdram_clk);
        check("mid_granted", 64'(acc_o), 64'(1));
        @(posedge sdram_clk); #1;
        sdram_rst = 1'b1;
        p_acc = 2'b11;
        @(posedge sdram_clk); #1;
        @(negedge sdram_clk);
        check("mid_rst_out", 64'({acc_o, p_ack_o, p_vld_o, err_o, dut_bus()}), 64'(0));
        @(posedge sdram_clk); #1;
        sdram_rst = 1'b0; p_we = 2'b11;
        @(negedge sdram_clk);
        check("mid_idle", 64'(acc_o), 64'(0));
        @(posedge sdram_clk); #1;
        @(negedge sdram_clk);
        ack_i = 1'b1;
        #1;
        check("mid_next_gnt", 64'({acc_o, p_ack_o}), 64'({1'b1, 2'b01}));
        @(posedge sdram_clk); #1;
        clear_inputs();
        vld_i = 1'b1;
        @(negedge sdram_clk);
        check("mid_stray_vld", 64'(p_vld_o), 64'(0));
        @(posedge sdram_clk); #1;
        vld_i = 1'b0;
        @(negedge sdram_clk);
        check("mid_stray_err", 64'(err_o), 64'(1));

        // ---- random run against the behavioural model
        @(posedge sdram_clk); #1;
        do_reset();
        model_reset();
        cyc = 0;
        repeat (2000) begin
            if ($urandom_range(0, 5) == 0) p_acc = p_acc ^ 2'b01;
            if ($urandom_range(0, 5) == 0) p_acc = p_acc ^ 2'b10;
            p_we  = 2'($urandom);
            p_adr = {$urandom, $urandom};
            p_dat = $urandom;
            p_sel = 4'($urandom);
            p_dv  = 2'($urandom);
            vld_i = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            adr_i = $urandom;
            dat_i = DQ'($urandom);
            ack_i = 1'b0;
            model_comb();
            ack_i = e_acc && ($urandom_range(0, 2) != 0);
            model_comb();
            @(negedge sdram_clk);
            check("rnd_acc", 64'(acc_o), 64'(e_acc));
            check("rnd_ack", 64'(p_ack_o), 64'(e_ack));
            check("rnd_vld", 64'(p_vld_o), 64'(e_vld));
            check("rnd_err", 64'(err_o), 64'(m_err));
            check("rnd_bus", 64'(dut_bus()), 64'(e_bus));
            check("rnd_rd", 64'({p_adr_o, p_dat_o}), 64'({adr_i, dat_i}));
            @(posedge sdram_clk);
            model_step();
            #1;
            cyc++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
